int_mem_boot_seq: RTL and testbench

//  Boot sequencer for the internal SoC memory. After reset it copies the boot ROM into the top of the

---
 rtl/int_mem_boot_seq.sv | 126 ++++++++++++
 tb/tb_int_mem_boot_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_mem_boot_seq.sv
// Boot sequencer: copies the boot ROM to the top of SRAM, then pulses the CPU reset and releases it.
// Optional running checksum of copied words when INT_MEM_BOOT_CHECKSUM_EN is defined.
module int_mem_boot_seq #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 12,
    parameter int ROM_ADDR_W  = 10,
    parameter int COPY_BASE   = 2**SRAM_ADDR_W - 2**ROM_ADDR_W,
    parameter int RST_PULSE   = 100
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cke_i,
    output logic                   rom_en_o,
    output logic [ROM_ADDR_W-1:0]  rom_addr_o,
    input  logic [DATA_W-1:0]      rom_rdata_i,
    output logic                   sram_req_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0]      sram_wdata_o,
    output logic [DATA_W/8-1:0]    sram_wstrb_o,
    input  logic                   sram_ack_i,
    input  logic                   ctrl_wr_i,
    input  logic [1:0]             ctrl_wdata_i,
    output logic                   boot_o,
    output logic                   cpu_rst_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef INT_MEM_BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]      checksum_o
`endif
);

    typedef enum logic [2:0] {ST_RD, ST_CAP, ST_WR, ST_PULSE, ST_RUN} state_t;

    // One counter serves as ROM word index during copy and as pulse timer afterwards.
    localparam int PULSE_W = $clog2(RST_PULSE + 1);
    localparam int CNT_W   = (ROM_ADDR_W > PULSE_W) ? ROM_ADDR_W : PULSE_W;
    localparam logic [CNT_W-1:0]       LAST_WORD  = CNT_W'(2**ROM_ADDR_W - 1);
    localparam logic [CNT_W-1:0]       LAST_PULSE = CNT_W'(RST_PULSE - 1);
    localparam logic [SRAM_ADDR_W-1:0] BASE       = SRAM_ADDR_W'(COPY_BASE);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              boot_q;
    logic              boot_nxt;
`ifdef INT_MEM_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= ST_RD;
            cnt      <= '0;
            wdata_q  <= '0;
            boot_q   <= 1'b1;
            boot_nxt <= 1'b1;
`ifdef INT_MEM_BOOT_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else if (cke_i) begin
            case (state)
                ST_RD:  state <= ST_CAP;
                ST_CAP: begin
                    wdata_q <= rom_rdata_i;
                    state   <= ST_WR;
                end
                ST_WR: begin
                    if (sram_ack_i) begin
`ifdef INT_MEM_BOOT_CHECKSUM_EN
                        sum_q <= sum_q + wdata_q;
`endif
                        if (cnt == LAST_WORD) begin
                            cnt   <= '0;
                            state <= ST_PULSE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ST_RD;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == LAST_PULSE) begin
                        cnt    <= '0;
                        boot_q <= boot_nxt;
                        state  <= ST_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ctrl_wr_i) begin
                        boot_nxt <= ctrl_wdata_i[0];
                        if (ctrl_wdata_i[1]) begin
                            cnt <= '0;
                            if (ctrl_wdata_i[0]) begin
                                state <= ST_RD;
`ifdef INT_MEM_BOOT_CHECKSUM_EN
                                sum_q <= '0;
`endif
                            end else begin
                                state <= ST_PULSE;
                            end
                        end
                    end
                end
                default: state <= ST_RD;
            endcase
        end
    end

    assign rom_en_o     = (state == ST_RD);
    assign rom_addr_o   = cnt[ROM_ADDR_W-1:0];
    assign sram_req_o   = (state == ST_WR);
    assign sram_addr_o  = BASE + SRAM_ADDR_W'(cnt[ROM_ADDR_W-1:0]);
    assign sram_wdata_o = wdata_q;
    assign sram_wstrb_o = {(DATA_W/8){sram_req_o}};
    assign boot_o       = boot_q;
    assign cpu_rst_o    = (state != ST_RUN);
    assign busy_o       = (state != ST_RUN);
    assign done_o       = (state == ST_RUN);
`ifdef INT_MEM_BOOT_CHECKSUM_EN
    assign checksum_o   = sum_q;
`endif

endmodule

// File: tb/tb_int_mem_boot_seq.sv
// Directed bench for int_mem_boot_seq with a 4-word ROM and 16-word SRAM model.
// Checksum checks compile in only when INT_MEM_BOOT_CHECKSUM_EN is defined.
module tb_int_mem_boot_seq;

    localparam int P = 5;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        cke_i;
    logic        rom_en_o;
    logic [1:0]  rom_addr_o;
    logic [31:0] rom_rdata_i;
    logic        sram_req_o;
    logic [3:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_wstrb_o;
    logic        sram_ack_i;
    logic        ctrl_wr_i;
    logic [1:0]  ctrl_wdata_i;
    logic        boot_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        done_o;
`ifdef INT_MEM_BOOT_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [4];
    logic [31:0] sram [16];
    int          wr_count = 0;
    int          rom_rd = 0;
    int          req_age = 0;
    logic [3:0]  delay_addr = 4'd0;
    int          delay_n = 0;

    always #5 clk = ~clk;

    int_mem_boot_seq #(
        .DATA_W      (32),
        .SRAM_ADDR_W (4),
        .ROM_ADDR_W  (2),
        .RST_PULSE   (P)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .cke_i        (cke_i),
        .rom_en_o     (rom_en_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rdata_i  (rom_rdata_i),
        .sram_req_o   (sram_req_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_wstrb_o (sram_wstrb_o),
        .sram_ack_i   (sram_ack_i),
        .ctrl_wr_i    (ctrl_wr_i),
        .ctrl_wdata_i (ctrl_wdata_i),
        .boot_o       (boot_o),
        .cpu_rst_o    (cpu_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef INT_MEM_BOOT_CHECKSUM_EN
        ,
        .checksum_o   (checksum_o)
`endif
    );

    // Synchronous ROM: data for the address presented with rom_en_o appears the next cycle.
    always @(posedge clk) if (rom_en_o) rom_rdata_i <= rom[rom_addr_o];

    // SRAM acks after a per-address latency; writes land only when the sequencer is live.
    assign sram_ack_i = sram_req_o && (req_age >= ((sram_addr_o == delay_addr) ? delay_n : 0));

    always @(posedge clk) begin
        if (rst_n_i && cke_i) begin
            if (rom_en_o) rom_rd++;
            if (sram_req_o && sram_ack_i) begin
                sram[sram_addr_o] = sram_wdata_o;
                wr_count++;
            end
            if (sram_req_o && !sram_ack_i) req_age++;
            else req_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 400) begin
            step();
            n++;
        end
        check(tag, {31'd0, done_o}, 32'd1);
    endtask

    task automatic check_sram(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        check({tag, "_m12"}, sram[12], w0);
        check({tag, "_m13"}, sram[13], w1);
        check({tag, "_m14"}, sram[14], w2);
        check({tag, "_m15"}, sram[15], w3);
    endtask

    task automatic ctrl_write(input logic [1:0] v);
        ctrl_wr_i    = 1'b1;
        ctrl_wdata_i = v;
        step();
        ctrl_wr_i    = 1'b0;
        ctrl_wdata_i = 2'b00;
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        cke_i = 1'b1;
        ctrl_wr_i = 1'b0;
        ctrl_wdata_i = 2'b00;
        rom[0] = 32'd11; rom[1] = 32'd22; rom[2] = 32'd33; rom[3] = 32'd44;
        for (int i = 0; i < 16; i++) sram[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_boot", {31'd0, boot_o}, 32'd1);
        check("rst_req", {31'd0, sram_req_o}, 32'd0);
        check("rst_wdata", sram_wdata_o, 32'd0);

        // 1: plain copy, immediate ack; count edges to CPU release
        wr_count = 0; rom_rd = 0;
        rst_n_i = 1'b1;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (!cpu_rst_o) break;
        end
        check("t1_release_cycles", n, 12 + P);
        check_sram("t1", 32'd11, 32'd22, 32'd33, 32'd44);
        check("t1_boot", {31'd0, boot_o}, 32'd1);
        check("t1_done", {31'd0, done_o}, 32'd1);
        check("t1_busy", {31'd0, busy_o}, 32'd0);
        check("t1_writes", wr_count, 4);
        check("t1_rom_reads", rom_rd, 4);
`ifdef INT_MEM_BOOT_CHECKSUM_EN
        check("t1_checksum", checksum_o, 32'd110);
`endif

        // 2: word 1 acked after 5 extra cycles; write must hold, no extra ROM read
        for (int i = 0; i < 16; i++) sram[i] = '0;
        delay_addr = 4'd13; delay_n = 5;
        rst_n_i = 1'b0;
        repeat (2) step();
        wr_count = 0; rom_rd = 0;
        rst_n_i = 1'b1;
        n = 0;
        while (!(sram_req_o && sram_addr_o == 4'd13) && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            check("t2_req_hold", {31'd0, sram_req_o}, 32'd1);
            check("t2_addr_hold", {28'd0, sram_addr_o}, 32'd13);
            check("t2_data_hold", sram_wdata_o, 32'd22);
            check("t2_strb", {28'd0, sram_wstrb_o}, 32'hF);
            check("t2_no_rom_rd", {31'd0, rom_en_o}, 32'd0);
            step();
        end
        check("t2_next_rd", {31'd0, rom_en_o}, 32'd1);
        check("t2_next_addr", {30'd0, rom_addr_o}, 32'd2);
        check("t2_strb_idle", {28'd0, sram_wstrb_o}, 32'd0);
        wait_run("t2_run");
        check_sram("t2", 32'd11, 32'd22, 32'd33, 32'd44);
        check("t2_writes", wr_count, 4);
        check("t2_rom_reads", rom_rd, 4);
`ifdef INT_MEM_BOOT_CHECKSUM_EN
        check("t2_checksum", checksum_o, 32'd110);
`endif
        delay_n = 0;

        // 3: software reset request with boot flag cleared
        wr_count = 0;
        ctrl_write(2'b10);
        check("t3_rst_rise", {31'd0, cpu_rst_o}, 32'd1);
        check("t3_busy", {31'd0, busy_o}, 32'd1);
        n = 1;
        while (n < 50) begin
            step();
            if (!cpu_rst_o) break;
            n++;
        end
        check("t3_pulse_len", n, P);
        check("t3_boot", {31'd0, boot_o}, 32'd0);
        check("t3_done", {31'd0, done_o}, 32'd1);
        check("t3_writes", wr_count, 0);

        // 4: full re-copy with new ROM; ctrl write mid-copy must be ignored
        rom[0] = 32'd1; rom[1] = 32'd1; rom[2] = 32'd1; rom[3] = 32'd1;
        wr_count = 0; rom_rd = 0;
        ctrl_write(2'b11);
        check("t4_done_low", {31'd0, done_o}, 32'd0);
        check("t4_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("t4_rd", {31'd0, rom_en_o}, 32'd1);
        check("t4_rd_addr", {30'd0, rom_addr_o}, 32'd0);
        repeat (2) step();
        ctrl_write(2'b10);
        wait_run("t4_run");
        check_sram("t4", 32'd1, 32'd1, 32'd1, 32'd1);
        check("t4_boot", {31'd0, boot_o}, 32'd1);
        check("t4_writes", wr_count, 4);
        check("t4_rom_reads", rom_rd, 4);
`ifdef INT_MEM_BOOT_CHECKSUM_EN
        check("t4_checksum", checksum_o, 32'd4);
`endif
        repeat (3) step();
        check("t4_stays_run", {31'd0, cpu_rst_o}, 32'd0);

        // 5: clock-enable freeze during WR, then reset during WR of word 2
        rom[0] = 32'd5; rom[1] = 32'd6; rom[2] = 32'd7; rom[3] = 32'd8;
        rst_n_i = 1'b0;
        repeat (2) step();
        rst_n_i = 1'b1;
        n = 0;
        while (!sram_req_o && n < 20) begin
            step();
            n++;
        end
        cke_i = 1'b0;
        wr_count = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_cke_req", {31'd0, sram_req_o}, 32'd1);
            check("t5_cke_addr", {28'd0, sram_addr_o}, 32'd12);
        end
        check("t5_cke_nowrite", wr_count, 0);
        cke_i = 1'b1;
        n = 0;
        while (!(sram_req_o && sram_addr_o == 4'd14) && n < 50) begin
            step();
            n++;
        end
        check("t5_reached_w2", {28'd0, sram_addr_o}, 32'd14);
        rst_n_i = 1'b0;
        step();
        check("t5_restart_rd", {31'd0, rom_en_o}, 32'd1);
        check("t5_restart_addr", {30'd0, rom_addr_o}, 32'd0);
        check("t5_restart_req", {31'd0, sram_req_o}, 32'd0);
        rom[0] = 32'd9; rom[1] = 32'd10; rom[2] = 32'd11; rom[3] = 32'd12;
        wr_count = 0; rom_rd = 0;
        rst_n_i = 1'b1;
        wait_run("t5_run");
        check_sram("t5", 32'd9, 32'd10, 32'd11, 32'd12);
        check("t5_writes", wr_count, 4);
        check("t5_rom_reads", rom_rd, 4);
        check("t5_boot", {31'd0, boot_o}, 32'd1);
`ifdef INT_MEM_BOOT_CHECKSUM_EN
        check("t5_checksum", checksum_o, 32'd42);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
